// File: rtl/squash_regs_pkg.sv
// Register map and bit positions for the solo-squash control/status window.
package squash_regs_pkg;
    localparam int WIN_BITS = 6;   // 64-byte window

    localparam logic [3:0] REG_ID      = 4'h0;
    localparam logic [3:0] REG_CTRL    = 4'h1;
    localparam logic [3:0] REG_STATUS  = 4'h2;
    localparam logic [3:0] REG_FRAME   = 4'h3;
    localparam logic [3:0] REG_SCRATCH = 4'h4;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_SOFT_RST = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_FRAME = 0;
    localparam int STAT_MISS  = 1;

    localparam logic [15:0] ID_MAGIC = 16'h5351;
endpackage

// File: rtl/squash_event_capture.sv
// Sticky frame/miss status bits and the free-running frame counter.
module squash_event_capture
    import squash_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        miss_tick,
    input  logic        status_wr,
    input  logic [1:0]  status_clr,
    input  logic        count_clr,
    output logic [1:0]  status,
    output logic [31:0] frame_count
);
    logic [1:0] set;
    logic [1:0] clr;

    always_comb begin
        set = '0;
        set[STAT_FRAME] = frame_tick;
        set[STAT_MISS]  = miss_tick;
        clr = status_wr ? status_clr : 2'b00;
    end

    // Setting is applied after clearing so a coincident tick survives W1C,
    // while a counter clear swallows a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            status      <= '0;
            frame_count <= '0;
        end else begin
            status <= (status & ~clr) | set;
            if (count_clr)
                frame_count <= '0;
            else if (frame_tick)
                frame_count <= frame_count + 32'd1;
        end
    end
endmodule

// File: rtl/wb_squash_regs.sv
// Wishbone classic register window for the solo-squash game: decode, ack,
// read mux, CTRL and SCRATCH; event capture lives in squash_event_capture.
module wb_squash_regs
    import squash_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [7:0]  PROJECT_ID = 8'd1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        active,
    input  logic        frame_tick,
    input  logic        miss_tick,
    output logic        game_enable,
    output logic        game_soft_reset,
    output logic        irq
);
    logic [3:0]  idx;
    logic        hit;
    logic        take;
    logic        wr;
    logic        ctrl_wr;
    logic        status_wr;
    logic        count_clr;
    logic        scratch_wr;
    logic        irq_en;
    logic [31:0] scratch;
    logic [1:0]  status;
    logic [31:0] frame_count;
    logic [31:0] rdata;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign idx  = wbs_adr_i[5:2];
    assign hit  = wbs_cyc_i & wbs_stb_i & active &
                  (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    // Ignoring the hit while ack is high yields one ack per two cycles.
    assign take = hit & ~wbs_ack_o;
    assign wr   = take & wbs_we_i;

    assign ctrl_wr    = wr & (idx == REG_CTRL)   & wbs_sel_i[0];
    assign status_wr  = wr & (idx == REG_STATUS) & wbs_sel_i[0];
    assign count_clr  = wr & (idx == REG_FRAME);
    assign scratch_wr = wr & (idx == REG_SCRATCH);

    squash_event_capture u_events (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .frame_tick  (frame_tick),
        .miss_tick   (miss_tick),
        .status_wr   (status_wr),
        .status_clr  (wbs_dat_i[1:0]),
        .count_clr   (count_clr),
        .status      (status),
        .frame_count (frame_count)
    );

    always_comb begin
        rdata = '0;
        case (idx)
            REG_ID:      rdata = {ID_MAGIC, 8'h00, PROJECT_ID};
            REG_CTRL: begin
                rdata[CTRL_ENABLE] = game_enable;
                rdata[CTRL_IRQ_EN] = irq_en;
            end
            REG_STATUS:  rdata[1:0] = status;
            REG_FRAME:   rdata = frame_count;
            REG_SCRATCH: rdata = scratch;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o       <= 1'b0;
            wbs_dat_o       <= '0;
            game_enable     <= 1'b0;
            irq_en          <= 1'b0;
            game_soft_reset <= 1'b0;
            scratch         <= '0;
        end else begin
            wbs_ack_o       <= take;
            wbs_dat_o       <= take ? rdata : 32'd0;
            game_soft_reset <= ctrl_wr & wbs_dat_i[CTRL_SOFT_RST];
            if (ctrl_wr) begin
                game_enable <= wbs_dat_i[CTRL_ENABLE];
                irq_en      <= wbs_dat_i[CTRL_IRQ_EN];
            end
            for (int b = 0; b < 4; b++)
                if (scratch_wr && wbs_sel_i[b])
                    scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
    end

    assign irq = irq_en & (|status);
endmodule

// File: tb/tb_wb_squash_regs.sv
// Randomized and directed checks of wb_squash_regs against a register-map model.
module tb_wb_squash_regs;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [7:0]  PID  = 8'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic        active = 1'b1;
    logic        frame_tick = 1'b0, miss_tick = 1'b0;
    logic        game_enable, game_soft_reset, irq;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;
    logic preload_req = 1'b0;

    wb_squash_regs #(.BASE_ADDR(BASE), .PROJECT_ID(PID)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .active(active), .frame_tick(frame_tick), .miss_tick(miss_tick),
        .game_enable(game_enable), .game_soft_reset(game_soft_reset), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_en = 0, m_irq_en = 0;
    logic        m_frame = 0, m_miss = 0;
    logic [31:0] m_count = 0, m_scratch = 0;
    logic        e_ack = 0, e_srst = 0;
    logic [31:0] e_dat = 0;

    function automatic logic [31:0] model_read(input logic [3:0] i);
        case (i)
            4'd0: return {16'h5351, 8'h00, PID};
            4'd1: return {29'd0, m_irq_en, 1'b0, m_en};
            4'd2: return {30'd0, m_miss, m_frame};
            4'd3: return m_count;
            4'd4: return m_scratch;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic        t;
        logic [3:0]  i;
        logic [31:0] rv;
        logic [1:0]  w1c;
        logic        cclr;
        if (preload_req) m_count = 32'hFFFF_FFFF;
        if (rst) begin
            m_en = 0; m_irq_en = 0; m_frame = 0; m_miss = 0;
            m_count = 0; m_scratch = 0; e_ack = 0; e_srst = 0; e_dat = 0;
        end else begin
            t = cyc && stb && active && (adr[31:6] == BASE[31:6]) && !e_ack;
            i = adr[5:2];
            rv = model_read(i);
            w1c = 2'b00; cclr = 0; e_srst = 0;
            if (t && we) begin
                if (i == 4'd1 && sel[0]) begin
                    m_en = wdat[0]; m_irq_en = wdat[2]; e_srst = wdat[1];
                end
                if (i == 4'd2 && sel[0]) w1c = wdat[1:0];
                if (i == 4'd3) cclr = 1;
                if (i == 4'd4)
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) m_scratch[8*b +: 8] = wdat[8*b +: 8];
            end
            m_frame = (m_frame && !w1c[0]) || frame_tick;
            m_miss  = (m_miss  && !w1c[1]) || miss_tick;
            m_count = cclr ? 32'd0 : m_count + (frame_tick ? 32'd1 : 32'd0);
            e_ack = t;
            e_dat = t ? rv : 32'd0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (cmp_on) begin
        check("ack", {31'd0, ack}, {31'd0, e_ack});
        check("dat", rdat, e_dat);
        check("game_enable", {31'd0, game_enable}, {31'd0, m_en});
        check("soft_reset", {31'd0, game_soft_reset}, {31'd0, e_srst});
        check("irq", {31'd0, irq}, {31'd0, m_irq_en & (m_frame | m_miss)});
    end

    // ---------------- directed helpers ----------------
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ft,
                        output logic [31:0] r, output logic sr);
        logic got;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; frame_tick = ft;
        got = 0; r = 32'd0; sr = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            frame_tick = 0;
            if (ack) begin got = 1; r = rdat; sr = game_soft_reset; end
        end
        cyc = 0; stb = 0; we = 0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd(input logic [7:0] ofs, input logic [31:0] exp, input string name);
        logic [31:0] r; logic sr;
        xfer(0, BASE + {24'd0, ofs}, 32'd0, 4'hF, 0, r, sr);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s,
                      input logic ft, output logic sr);
        logic [31:0] r;
        xfer(1, BASE + {24'd0, ofs}, d, s, ft, r, sr);
    endtask

    task automatic pulse(input logic f, input logic m);
        @(negedge clk); frame_tick = f; miss_tick = m;
        @(negedge clk); frame_tick = 0; miss_tick = 0;
    endtask

    initial begin
        logic sr;
        @(posedge clk); @(negedge clk);
        cmp_on = 1;
        @(negedge clk); @(negedge clk);
        check("reset_enable", {31'd0, game_enable}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst = 0;

        rd(8'h00, 32'h5351_0001, "id");
        rd(8'h04, 32'd0, "ctrl_rst");
        rd(8'h08, 32'd0, "status_rst");
        rd(8'h0C, 32'd0, "count_rst");
        rd(8'h10, 32'd0, "scratch_rst");
        rd(8'h3C, 32'd0, "unmapped");

        wr(8'h10, 32'hDEAD_BEEF, 4'b0101, 0, sr);
        rd(8'h10, 32'h00AD_00EF, "scratch_sel");

        wr(8'h04, 32'h7, 4'hF, 0, sr);
        check("soft_reset_pulse", {31'd0, sr}, 32'd1);
        rd(8'h04, 32'h5, "ctrl_read");
        check("enable_set", {31'd0, game_enable}, 32'd1);

        pulse(1, 0); pulse(1, 1); pulse(1, 0);
        rd(8'h0C, 32'd3, "count3");
        rd(8'h08, 32'd3, "status3");
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(8'h08, 32'd1, 4'hF, 1, sr);
        rd(8'h08, 32'd3, "w1c_vs_tick");
        wr(8'h08, 32'd3, 4'hF, 0, sr);
        rd(8'h08, 32'd0, "w1c_clear");
        check("irq_clear", {31'd0, irq}, 32'd0);

        @(negedge clk);
        active = 0; cyc = 1; stb = 1; we = 0; adr = BASE;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("inactive_ack", {31'd0, ack}, 32'd0);
            check("inactive_dat", rdat, 32'd0);
        end
        active = 1; adr = BASE + 32'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("outside_ack", {31'd0, ack}, 32'd0);
        end
        cyc = 0; stb = 0;

        @(negedge clk);
        force dut.u_events.frame_count = 32'hFFFF_FFFF;
        preload_req = 1;
        #1 release dut.u_events.frame_count;
        @(negedge clk); preload_req = 0;
        rd(8'h0C, 32'hFFFF_FFFF, "count_preload");
        pulse(1, 0);
        rd(8'h0C, 32'd0, "count_wrap");

        @(negedge clk);
        rst = 1; cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; wdat = 32'h1234_5678; sel = 4'hF;
        @(negedge clk);
        check("reset_write_ack", {31'd0, ack}, 32'd0);
        rst = 0; cyc = 0; stb = 0; we = 0;
        rd(8'h10, 32'd0, "reset_write_dropped");

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            cyc = ($urandom_range(0, 3) != 0);
            stb = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1) == 1;
            sel = 4'($urandom_range(0, 15));
            wdat = $urandom;
            adr = ($urandom_range(0, 9) == 0) ? $urandom
                  : BASE + {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) adr = BASE + 32'h40;
            active = ($urandom_range(0, 7) != 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            miss_tick  = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0; frame_tick = 0; miss_tick = 0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
